// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bundle between the two producers (ALU port A, LSU port B) and the
// register-file write port, including the queued-destination mask for hazard logic.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            a_valid;
    logic            a_ready;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_wdata;
    logic            b_valid;
    logic            b_ready;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_wdata;
    logic            reg_we;
    logic [4:0]      reg_rd;
    logic [XLEN-1:0] reg_wdata;
    logic [31:0]     pend_mask;

    modport master (
        output a_valid, a_rd, a_wdata, b_valid, b_rd, b_wdata,
        input  a_ready, b_ready, reg_we, reg_rd, reg_wdata, pend_mask
    );

    modport slave (
        input  a_valid, a_rd, a_wdata, b_valid, b_rd, b_wdata,
        output a_ready, b_ready, reg_we, reg_rd, reg_wdata, pend_mask
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two DEPTH-entry writeback FIFOs drained round-robin into one registered
// register-file write port; pend_mask flags every destination still in flight.
module regfile_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    function automatic logic [31:0] dec(input logic [4:0] r);
        dec = 32'd1 << r;
    endfunction

    logic [4:0]      a_rd_q    [DEPTH];
    logic [XLEN-1:0] a_wdata_q [DEPTH];
    logic [4:0]      b_rd_q    [DEPTH];
    logic [XLEN-1:0] b_wdata_q [DEPTH];

    logic [AW:0]     a_wp_q, a_wp_d, a_rp_q, a_rp_d;
    logic [AW:0]     b_wp_q, b_wp_d, b_rp_q, b_rp_d;
    logic            last_b_q, last_b_d;
    logic            reg_we_q, reg_we_d;
    logic [4:0]      reg_rd_q, reg_rd_d;
    logic [XLEN-1:0] reg_wdata_q, reg_wdata_d;

    logic            a_full, a_empty, b_full, b_empty;
    logic            a_push, b_push, pop_a, pop_b;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_wdata;
    logic [AW:0]     a_cnt, b_cnt;
    logic [AW-1:0]   a_off, b_off;
    logic [31:0]     pend;

    assign a_full  = (a_wp_q[AW] != a_rp_q[AW]) && (a_wp_q[AW-1:0] == a_rp_q[AW-1:0]);
    assign b_full  = (b_wp_q[AW] != b_rp_q[AW]) && (b_wp_q[AW-1:0] == b_rp_q[AW-1:0]);
    assign a_empty = (a_wp_q == a_rp_q);
    assign b_empty = (b_wp_q == b_rp_q);
    assign a_push  = bus.a_valid && !a_full;
    assign b_push  = bus.b_valid && !b_full;

    always_comb begin
        pop_a = 1'b0;
        pop_b = 1'b0;
        // On a tie the port that did not win last time goes next.
        if (!a_empty && !b_empty) begin
            pop_a = last_b_q;
            pop_b = !last_b_q;
        end else begin
            pop_a = !a_empty;
            pop_b = !b_empty;
        end

        head_rd    = pop_b ? b_rd_q[b_rp_q[AW-1:0]]    : a_rd_q[a_rp_q[AW-1:0]];
        head_wdata = pop_b ? b_wdata_q[b_rp_q[AW-1:0]] : a_wdata_q[a_rp_q[AW-1:0]];

        a_wp_d = a_wp_q + {{AW{1'b0}}, a_push};
        b_wp_d = b_wp_q + {{AW{1'b0}}, b_push};
        a_rp_d = a_rp_q + {{AW{1'b0}}, pop_a};
        b_rp_d = b_rp_q + {{AW{1'b0}}, pop_b};

        last_b_d = last_b_q;
        if (pop_a)      last_b_d = 1'b0;
        else if (pop_b) last_b_d = 1'b1;

        // x0 entries are consumed like any other but never raise the write enable.
        reg_we_d    = (pop_a || pop_b) && (head_rd != 5'd0);
        reg_rd_d    = reg_rd_q;
        reg_wdata_d = reg_wdata_q;
        if (pop_a || pop_b) begin
            reg_rd_d    = head_rd;
            reg_wdata_d = head_wdata;
        end
    end

    always_comb begin
        pend  = '0;
        a_off = '0;
        b_off = '0;
        a_cnt = a_wp_q - a_rp_q;
        b_cnt = b_wp_q - b_rp_q;
        for (int i = 0; i < DEPTH; i++) begin
            a_off = AW'(i) - a_rp_q[AW-1:0];
            b_off = AW'(i) - b_rp_q[AW-1:0];
            if ({1'b0, a_off} < a_cnt) pend = pend | dec(a_rd_q[i]);
            if ({1'b0, b_off} < b_cnt) pend = pend | dec(b_rd_q[i]);
        end
        if (reg_we_q) pend = pend | dec(reg_rd_q);
        pend[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (a_push) begin
            a_rd_q[a_wp_q[AW-1:0]]    <= bus.a_rd;
            a_wdata_q[a_wp_q[AW-1:0]] <= bus.a_wdata;
        end
        if (b_push) begin
            b_rd_q[b_wp_q[AW-1:0]]    <= bus.b_rd;
            b_wdata_q[b_wp_q[AW-1:0]] <= bus.b_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_wp_q      <= '0;
            a_rp_q      <= '0;
            b_wp_q      <= '0;
            b_rp_q      <= '0;
            last_b_q    <= 1'b1;
            reg_we_q    <= 1'b0;
            reg_rd_q    <= '0;
            reg_wdata_q <= '0;
        end else begin
            a_wp_q      <= a_wp_d;
            a_rp_q      <= a_rp_d;
            b_wp_q      <= b_wp_d;
            b_rp_q      <= b_rp_d;
            last_b_q    <= last_b_d;
            reg_we_q    <= reg_we_d;
            reg_rd_q    <= reg_rd_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    assign bus.a_ready   = !a_full;
    assign bus.b_ready   = !b_full;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_rd    = reg_rd_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.pend_mask = pend;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a per-cycle vector table plus streamed
// sequences for contention, backpressure, reset and pointer wrap-around.
module tb_regfile_wb_arbiter;
    logic clk;
    logic rst;

    regfile_wb_arbiter_if #(.XLEN(32)) bus ();

    regfile_wb_arbiter #(.XLEN(32), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] awd;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bwd;
        logic        e_ardy;
        logic        e_brdy;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic [31:0] e_pm;
    } vec_t;

    int   checks;
    int   errors;
    bit   mon_en;
    bit   acc_a, acc_b;
    bit   a_low, b_low;
    ent_t src_a[$];
    ent_t src_b[$];
    ent_t exp_q[$];
    vec_t tbl[11];

    function automatic ent_t mk(input logic [4:0] r, input logic [31:0] d);
        ent_t e;
        e.rd = r;
        e.wd = d;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // One clock: note handshakes before the edge, sample outputs 1 time unit after it.
    task automatic tick();
        ent_t e;
        acc_a = bus.a_valid && bus.a_ready;
        acc_b = bus.b_valid && bus.b_ready;
        @(posedge clk);
        #1;
        if (!bus.a_ready) a_low = 1'b1;
        if (!bus.b_ready) b_low = 1'b1;
        if (mon_en && bus.reg_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_rd", 32'(bus.reg_rd), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("issue_rd", 32'(bus.reg_rd), 32'(e.rd));
                chk("issue_wdata", bus.reg_wdata, e.wd);
            end
        end
    endtask

    task automatic idle_inputs();
        bus.a_valid = 1'b0;
        bus.a_rd    = '0;
        bus.a_wdata = '0;
        bus.b_valid = 1'b0;
        bus.b_rd    = '0;
        bus.b_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_low = 1'b0;
        b_low = 1'b0;
        exp_q.delete();
        src_a.delete();
        src_b.delete();
    endtask

    task automatic run_streams(input string nm, input int budget, input bit gaps);
        for (int c = 0; c < budget; c++) begin
            if (src_a.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                bus.a_valid = 1'b1;
                bus.a_rd    = src_a[0].rd;
                bus.a_wdata = src_a[0].wd;
            end else begin
                bus.a_valid = 1'b0;
            end
            if (src_b.size() > 0) begin
                bus.b_valid = 1'b1;
                bus.b_rd    = src_b[0].rd;
                bus.b_wdata = src_b[0].wd;
            end else begin
                bus.b_valid = 1'b0;
            end
            tick();
            if (acc_a) void'(src_a.pop_front());
            if (acc_b) void'(src_b.pop_front());
            if (src_a.size() == 0 && src_b.size() == 0 && exp_q.size() == 0) break;
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) tick();
        chk({nm, "_pending_expected"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_unsent_a"}, 32'(src_a.size()), 32'd0);
        chk({nm, "_unsent_b"}, 32'(src_b.size()), 32'd0);
        chk({nm, "_pend_mask_idle"}, bus.pend_mask, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        a_low  = 1'b0;
        b_low  = 1'b0;
        idle_inputs();

        //            av    ard    awd           bv    brd    bwd        ardy  brdy  we    rd     wd            pm
        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,     1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0000_0020};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,     1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0000_0020};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,     1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0};
        tbl[3]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,     1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,     1'b1, 1'b1, 1'b0, 5'd0, 32'h1234,     32'h0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,     1'b1, 1'b1, 1'b0, 5'd0, 32'h1234,     32'h0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77,    1'b1, 1'b1, 1'b0, 5'd0, 32'h1234,     32'h0000_0080};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd8, 32'h88,    1'b1, 1'b1, 1'b1, 5'd7, 32'h77,       32'h0000_0180};
        tbl[8]  = '{1'b1, 5'd3, 32'h33,       1'b0, 5'd0, 32'h0,     1'b1, 1'b1, 1'b1, 5'd8, 32'h88,       32'h0000_0108};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,     1'b1, 1'b1, 1'b1, 5'd3, 32'h33,       32'h0000_0008};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,     1'b1, 1'b1, 1'b0, 5'd3, 32'h33,       32'h0};

        // Power-on reset state.
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_reg_we", 32'(bus.reg_we), 32'd0);
        chk("reset_reg_rd", 32'(bus.reg_rd), 32'd0);
        chk("reset_reg_wdata", bus.reg_wdata, 32'd0);
        chk("reset_pend_mask", bus.pend_mask, 32'd0);
        rst = 1'b0;
        chk("reset_a_ready", 32'(bus.a_ready), 32'd1);
        chk("reset_b_ready", 32'(bus.b_ready), 32'd1);

        // Single write, x0 handling and single-port issue timing.
        for (int i = 0; i < 11; i++) begin
            bus.a_valid = tbl[i].av;
            bus.a_rd    = tbl[i].ard;
            bus.a_wdata = tbl[i].awd;
            bus.b_valid = tbl[i].bv;
            bus.b_rd    = tbl[i].brd;
            bus.b_wdata = tbl[i].bwd;
            tick();
            chk($sformatf("vec%0d_a_ready", i), 32'(bus.a_ready), 32'(tbl[i].e_ardy));
            chk($sformatf("vec%0d_b_ready", i), 32'(bus.b_ready), 32'(tbl[i].e_brdy));
            chk($sformatf("vec%0d_reg_we", i), 32'(bus.reg_we), 32'(tbl[i].e_we));
            chk($sformatf("vec%0d_reg_rd", i), 32'(bus.reg_rd), 32'(tbl[i].e_rd));
            chk($sformatf("vec%0d_reg_wdata", i), bus.reg_wdata, tbl[i].e_wd);
            chk($sformatf("vec%0d_pend_mask", i), bus.pend_mask, tbl[i].e_pm);
        end
        idle_inputs();

        // Reset mid-stream with entries queued and a write on the port.
        do_reset();
        bus.a_valid = 1'b1; bus.a_rd = 5'd4; bus.a_wdata = 32'h44;
        bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_wdata = 32'h99;
        tick();
        bus.a_rd = 5'd6;  bus.a_wdata = 32'h66;
        bus.b_rd = 5'd10; bus.b_wdata = 32'hA0;
        tick();
        chk("rstmid_we_before", 32'(bus.reg_we), 32'd1);
        chk("rstmid_rd_before", 32'(bus.reg_rd), 32'd4);
        chk("rstmid_b_full", 32'(bus.b_ready), 32'd0);
        chk("rstmid_pend_before", bus.pend_mask, 32'h0000_0650);
        bus.a_valid = 1'b0;
        bus.b_rd = 5'd11; bus.b_wdata = 32'hBB;
        tick();
        bus.b_valid = 1'b0;
        chk("rstmid_tie_goes_b", 32'(bus.reg_rd), 32'd9);
        chk("rstmid_pend_second", bus.pend_mask, 32'h0000_0640);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_we_now", 32'(bus.reg_we), 32'd0);
        chk("rstmid_pend_now", bus.pend_mask, 32'd0);
        chk("rstmid_rd_now", 32'(bus.reg_rd), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        exp_q.delete();
        for (int c = 0; c < 5; c++) tick();
        chk("rstmid_pend_after", bus.pend_mask, 32'd0);
        chk("rstmid_a_ready_after", 32'(bus.a_ready), 32'd1);
        chk("rstmid_b_ready_after", 32'(bus.b_ready), 32'd1);

        // Contention: both ports push every cycle, issue order 1,9,2,10,3,11.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            src_a.push_back(mk(5'(i), 32'hA000 + 32'(i)));
            src_b.push_back(mk(5'(i + 8), 32'hB000 + 32'(i + 8)));
        end
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(mk(5'(i), 32'hA000 + 32'(i)));
            exp_q.push_back(mk(5'(i + 8), 32'hB000 + 32'(i + 8)));
        end
        run_streams("contention", 40, 1'b0);
        chk("contention_a_ready_dropped", 32'(a_low), 32'd1);

        // B alone streams at the drain rate and never sees backpressure.
        do_reset();
        for (int i = 20; i <= 25; i++) begin
            src_b.push_back(mk(5'(i), 32'hC000 + 32'(i)));
            exp_q.push_back(mk(5'(i), 32'hC000 + 32'(i)));
        end
        run_streams("b_only", 40, 1'b0);
        chk("b_only_ready_never_low", 32'(b_low), 32'd0);

        // Sustained ties: each port issues every other cycle and fills up.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src_a.push_back(mk(5'(12 + i), 32'hD000 + 32'(i)));
            src_b.push_back(mk(5'(16 + i), 32'hE000 + 32'(i)));
            exp_q.push_back(mk(5'(12 + i), 32'hD000 + 32'(i)));
            exp_q.push_back(mk(5'(16 + i), 32'hE000 + 32'(i)));
        end
        run_streams("ties", 60, 1'b0);
        chk("ties_a_ready_dropped", 32'(a_low), 32'd1);
        chk("ties_b_ready_dropped", 32'(b_low), 32'd1);

        // Pointer wrap-around: 4*DEPTH+1 pushes on A with random valid gaps.
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            ent_t e;
            e = mk(5'(i), $urandom);
            src_a.push_back(e);
            exp_q.push_back(e);
        end
        run_streams("wrap", 200, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
